// File: rtl/bit_serializer_pkg.sv
// ---------------------------------------------------------------------------
// bit_serializer_pkg
// Shared definitions for the parallel-to-serial stage that feeds the serial
// sequence detector.
//   state_t      : FSM state encoding (IDLE / SHIFT / PAR)
//   cnt_width()  : width of the bit-position counter for a given word width
//   even_parity(): XOR reduction of a (zero-extended) word
// Optional feature macro used by the importers: BIT_SERIALIZER_PARITY_EN.
// ---------------------------------------------------------------------------
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        PAR   = 2'b10
    } state_t;

    // Counter width for a word of 'width' bits; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 32'sd1) ? $clog2(width) : 32'sd1;
    endfunction

    // Even parity bit of a word; callers zero-extend narrower words to 32 bits.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage : bit_serializer_pkg

// File: rtl/bit_counter.sv
// ---------------------------------------------------------------------------
// bit_counter
// Bit-position counter for the serializer. Counts 0..LIMIT-1 while enabled,
// wraps to 0 after LIMIT-1, and decodes the terminal and pre-terminal counts.
// Ports:
//   clk      in  clock, rising edge
//   rstn     in  asynchronous active-low reset
//   clr      in  synchronous clear to 0 (wins over en)
//   en       in  advance one position
//   last     out count == LIMIT-1 (last bit of a frame)
//   pre_last out count == LIMIT-2 (next bit is the last one)
// ---------------------------------------------------------------------------
module bit_counter
    import bit_serializer_pkg::*;
#(
    parameter int unsigned LIMIT = 8,
    parameter int unsigned CW    = cnt_width(LIMIT)
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic last,
    output logic pre_last
);

    localparam logic [CW-1:0] LAST_C = CW'(LIMIT - 32'd1);
    localparam logic [CW-1:0] PRE_C  = CW'(LIMIT - 32'd2);

    logic [CW-1:0] cnt_r;

    // Position counter: clear on a new word, wrap at the frame boundary.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r == LAST_C) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1'b1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last     = (cnt_r == LAST_C);
    assign pre_last = (cnt_r == PRE_C);

endmodule : bit_counter

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one
// bit per clock on x_out, which drives the sequence detector's x_in. x_out is
// held at 0 between frames; back-to-back frames run with no gap bit.
// Parameters:
//   WIDTH     : word width, 2..32
//   MSB_FIRST : 1 = bit WIDTH-1 first, 0 = bit 0 first
// Ports:
//   clk        in  clock, rising edge
//   rstn       in  asynchronous active-low reset
//   data_in    in  word to serialize (sampled on an accepted load)
//   load_valid in  producer has a word on data_in
//   load_ready out block can accept a word this cycle (decoded, not registered)
//   x_out      out serial bit (registered)
//   x_valid    out x_out carries a frame bit (registered)
//   frame_done out pulse with the final bit of a frame (registered)
// Optional feature: define BIT_SERIALIZER_PARITY_EN to append one even-parity
// bit (state PAR) after the data bits; frame length becomes WIDTH+1.
// ---------------------------------------------------------------------------
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             frame_done
);

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam bit PARITY_C = 1'b1;
`else
    localparam bit PARITY_C = 1'b0;
`endif

    state_t           state_r;
    logic [WIDTH-1:0] shreg_r;
    logic             x_out_r;
    logic             x_valid_r;
    logic             frame_done_r;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             parity_r;
`endif

    logic             ready_s;
    logic             accept_s;
    logic             cnt_en_s;
    logic             last_s;
    logic             pre_last_s;

    // First bit to present for a word.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return w[WIDTH-1];
        end else begin
            return w[0];
        end
    endfunction

    // Word with its head bit consumed, zero-filled from the far end.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return {w[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, w[WIDTH-1:1]};
        end
    endfunction

    // Ready decode: idle, or the final cycle of a frame; forced low in reset.
    always_comb begin
        ready_s = 1'b0;
        if (!rstn) begin
            ready_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    ready_s = 1'b1;
                SHIFT:   ready_s = last_s && !PARITY_C;
`ifdef BIT_SERIALIZER_PARITY_EN
                PAR:     ready_s = 1'b1;
`endif
                default: ready_s = 1'b0;
            endcase
        end
    end

    assign accept_s = load_valid && ready_s;
    assign cnt_en_s = (state_r == SHIFT);

    // A new word restarts the counter at position 0 (its first bit is
    // already on x_out in the following cycle).
    bit_counter #(
        .LIMIT (WIDTH)
    ) u_bit_counter (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (accept_s),
        .en       (cnt_en_s),
        .last     (last_s),
        .pre_last (pre_last_s)
    );

    // Frame FSM with registered serial outputs. Outputs are loaded one edge
    // ahead, so frame_done is armed while the counter sits on the
    // second-to-last data bit (or on the last one when parity follows).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= IDLE;
            shreg_r      <= '0;
            x_out_r      <= 1'b0;
            x_valid_r    <= 1'b0;
            frame_done_r <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r      <= SHIFT;
                        x_out_r      <= head_bit(data_in);
                        shreg_r      <= shift_word(data_in);
                        x_valid_r    <= 1'b1;
                        frame_done_r <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
                        parity_r     <= even_parity(32'(data_in));
`endif
                    end else begin
                        state_r      <= IDLE;
                        shreg_r      <= '0;
                        x_out_r      <= 1'b0;
                        x_valid_r    <= 1'b0;
                        frame_done_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!last_s) begin
                        state_r      <= SHIFT;
                        x_out_r      <= head_bit(shreg_r);
                        shreg_r      <= shift_word(shreg_r);
                        x_valid_r    <= 1'b1;
                        frame_done_r <= pre_last_s && !PARITY_C;
`ifdef BIT_SERIALIZER_PARITY_EN
                    end else begin
                        state_r      <= PAR;
                        x_out_r      <= parity_r;
                        shreg_r      <= '0;
                        x_valid_r    <= 1'b1;
                        frame_done_r <= 1'b1;
                    end
`else
                    end else if (accept_s) begin
                        state_r      <= SHIFT;
                        x_out_r      <= head_bit(data_in);
                        shreg_r      <= shift_word(data_in);
                        x_valid_r    <= 1'b1;
                        frame_done_r <= 1'b0;
                    end else begin
                        state_r      <= IDLE;
                        shreg_r      <= '0;
                        x_out_r      <= 1'b0;
                        x_valid_r    <= 1'b0;
                        frame_done_r <= 1'b0;
                    end
`endif
                end
`ifdef BIT_SERIALIZER_PARITY_EN
                PAR: begin
                    if (accept_s) begin
                        state_r      <= SHIFT;
                        x_out_r      <= head_bit(data_in);
                        shreg_r      <= shift_word(data_in);
                        x_valid_r    <= 1'b1;
                        frame_done_r <= 1'b0;
                        parity_r     <= even_parity(32'(data_in));
                    end else begin
                        state_r      <= IDLE;
                        shreg_r      <= '0;
                        x_out_r      <= 1'b0;
                        x_valid_r    <= 1'b0;
                        frame_done_r <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_r      <= IDLE;
                    shreg_r      <= '0;
                    x_out_r      <= 1'b0;
                    x_valid_r    <= 1'b0;
                    frame_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = ready_s;
    assign x_out      = x_out_r;
    assign x_valid    = x_valid_r;
    assign frame_done = frame_done_r;

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_bit_serializer
// Drives one MSB-first and one LSB-first serializer (WIDTH=8) from the same
// producer and compares every output cycle against a word-level model: a
// frame of word w is the list of its bits in the chosen order, optionally
// followed by ^w when BIT_SERIALIZER_PARITY_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk;
    logic       rstn;
    logic [7:0] data_in;
    logic       load_valid;
    logic       m_ready, m_x, m_xv, m_fd;
    logic       l_ready, l_x, l_xv, l_fd;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] words [4];

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .rstn       (rstn),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (m_ready),
        .x_out      (m_x),
        .x_valid    (m_xv),
        .frame_done (m_fd)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .rstn       (rstn),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (l_ready),
        .x_out      (l_x),
        .x_valid    (l_xv),
        .frame_done (l_fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected bit at frame position p of word w.
    function automatic logic exp_bit(input logic [7:0] w, input int p, input bit msb);
        if (p >= 8) return ^w;
        return msb ? w[7 - p] : w[p];
    endfunction

    task automatic check_idle(input logic exp_ready);
        chk("m_idle_x",     32'(m_x),     32'd0);
        chk("m_idle_valid", 32'(m_xv),    32'd0);
        chk("m_idle_done",  32'(m_fd),    32'd0);
        chk("m_idle_ready", 32'(m_ready), 32'(exp_ready));
        chk("l_idle_x",     32'(l_x),     32'd0);
        chk("l_idle_valid", 32'(l_xv),    32'd0);
        chk("l_idle_done",  32'(l_fd),    32'd0);
        chk("l_idle_ready", 32'(l_ready), 32'(exp_ready));
    endtask

    // Send words[0..n-1] back-to-back and check every cycle of the stream.
    // With junk set, random words are offered while ready is low during the
    // final frame; they must be ignored. Entry/exit: #1 after a rising edge,
    // both DUTs idle.
    task automatic play_burst(input int n, input bit junk);
        int j;
        int p;
        load_valid = 1'b1;
        data_in    = words[0];
        chk("m_ready_before_load", 32'(m_ready), 32'd1);
        @(posedge clk); #1;
        for (int c = 0; c < n * FL; c++) begin
            j = c / FL;
            p = c % FL;
            chk("m_x_out",      32'(m_x),     32'(exp_bit(words[j], p, 1'b1)));
            chk("m_x_valid",    32'(m_xv),    32'd1);
            chk("m_frame_done", 32'(m_fd),    32'(p == FL - 1));
            chk("m_load_ready", 32'(m_ready), 32'(p == FL - 1));
            chk("l_x_out",      32'(l_x),     32'(exp_bit(words[j], p, 1'b0)));
            chk("l_x_valid",    32'(l_xv),    32'd1);
            chk("l_frame_done", 32'(l_fd),    32'(p == FL - 1));
            chk("l_load_ready", 32'(l_ready), 32'(p == FL - 1));
            if (j + 1 < n) begin
                load_valid = 1'b1;
                data_in    = words[j + 1];
            end else if (junk && p != FL - 1) begin
                load_valid = 1'b1;
                data_in    = 8'($urandom);
            end else begin
                load_valid = 1'b0;
                data_in    = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        check_idle(1'b1);
    endtask

    initial begin
        rstn       = 1'b0;
        load_valid = 1'b0;
        data_in    = 8'h00;

        // Reset held for three cycles, then released with no load.
        repeat (3) begin
            @(posedge clk); #1;
            check_idle(1'b0);
        end
        rstn = 1'b1;
        #1;
        check_idle(1'b1);
        repeat (2) begin
            @(posedge clk); #1;
            check_idle(1'b1);
        end

        // Single frame; loads offered mid-frame are ignored.
        words[0] = 8'b1011_0010;
        play_burst(1, 1'b1);

        // Back-to-back frames, no gap.
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        play_burst(2, 1'b0);

        // Word whose LSB-first stream is 1,1,0,0,0,0,0,0.
        words[0] = 8'b0000_0011;
        play_burst(1, 1'b0);

        // Random bursts.
        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(1, 3));
            for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
            play_burst(n, 1'($urandom_range(0, 1)));
        end

        // Reset during the fourth bit of 8'hFF.
        load_valid = 1'b1;
        data_in    = 8'hFF;
        @(posedge clk); #1;
        load_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("m_bit4_valid", 32'(m_xv), 32'd1);
        chk("m_bit4_x",     32'(m_x),  32'd1);
        rstn = 1'b0;
        #1;
        check_idle(1'b0);
        @(posedge clk); #1;
        check_idle(1'b0);
        rstn = 1'b1;
        #1;
        check_idle(1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            check_idle(1'b1);
        end
        words[0] = 8'($urandom);
        play_burst(1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bit_serializer

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of the serial sequence-detector FSM and drives its x_in.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on x_out.
- x_out is held at 0 between frames, so the downstream detector returns to its idle state.
- Supports back-to-back frames with no gap bit.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted first; 0 = bit 0 is shifted first.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- data_in  in  WIDTH  word to serialize; sampled only on an accepted load.
- load_valid  in  1  producer has a word on data_in.
- load_ready  out  1  block can accept a word this cycle.
- x_out  out  1  serial bit stream; connects to the detector's x_in.
- x_valid  out  1  x_out carries a frame bit this cycle.
- frame_done  out  1  one-cycle pulse coincident with the final bit of a frame.

Behaviour:
- Reset (rstn low, asynchronous): x_out=0, x_valid=0, frame_done=0, load_ready=0, state=IDLE, shift register and bit counter cleared.
- Reset mid-frame discards the frame; no partial bits appear after reset release.
- load_ready goes to 1 in the first cycle after rstn deasserts.
- All outputs are registered except load_ready, which is decoded from state and counter.
- States:
  - IDLE: load_ready=1, x_out=0, x_valid=0. An accepted load (load_valid && load_ready at a rising edge) captures data_in and moves to SHIFT.
  - SHIFT: presents one bit per cycle; the counter runs 0..WIDTH-1.
  - PAR: present only with the optional feature; see Optional Feature.
- Latency: a load accepted at edge k puts the first bit on x_out, with x_valid=1, in the cycle after edge k. The last data bit is presented in cycle k+WIDTH.
- frame_done=1 in the cycle of the last data bit (or in the parity cycle when the feature is in).
- load_ready=1 during the last bit cycle of SHIFT (or PAR), so back-to-back frames are possible:
  - Accepted there: the next word's first bit follows immediately, with no idle cycle and x_valid continuously 1.
  - Not accepted: return to IDLE; x_out=0 and x_valid=0 from the next cycle.
- A load presented while load_ready=0 is ignored and is not captured. The producer must hold load_valid and data_in stable until it is accepted.
- Bit order follows MSB_FIRST. The shift register shifts left (MSB_FIRST=1) or right (MSB_FIRST=0) and zero-fills.
- The counter is $clog2(WIDTH) bits wide and wraps to 0 on the frame boundary.
- No simultaneous-event hazard other than reset, which always wins.

Optional Feature:
- Macro: BIT_SERIALIZER_PARITY_EN.
- Defined:
  - After the WIDTH data bits, state PAR presents one even-parity bit (XOR of the captured word) with x_valid=1.
  - frame_done and load_ready move to the PAR cycle. Frame length is WIDTH+1 cycles.
  - The parity value is computed at capture and stored in a 1-bit register.
- Undefined: no PAR state, no parity register; frame length is WIDTH cycles.

Decomposition:
- Shared package bit_serializer_pkg:
  - State encoding: IDLE=2'b00, SHIFT=2'b01, PAR=2'b10.
  - Localparam helper for counter width.
- Sub-module: bit_counter. A parameterized up-counter with clear, enable and a terminal-count output. It generates the last-bit decode. Everything else lives in the top.

Test Plan:
- Reset then idle: rstn low 3 cycles, release, no load -> x_out=0, x_valid=0, frame_done=0, load_ready=1 from first cycle after release.
- Single frame, MSB_FIRST=1, WIDTH=8, data_in=8'b1011_0010 accepted at edge k:
  - Cycles k+1..k+8 give x_out=1,0,1,1,0,0,1,0 with x_valid=1.
  - frame_done=1 only in cycle k+8; x_out=0, x_valid=0 in cycle k+9.
- Back-to-back: 8'hA5 then 8'h3C, with load_valid held high -> 16 contiguous valid bits 10100101_00111100, no gap; frame_done pulses at bits 8 and 16.
- LSB-first: MSB_FIRST=0, data 8'b0000_0011 -> bit stream 1,1,0,0,0,0,0,0. Fed into the detector, y_out=1 in the third bit cycle.
- Reset mid-frame: rstn asserted during bit 4 of 8'hFF -> x_out=0 and x_valid=0 immediately. After release there are no residual bits; the next load starts cleanly.
- BIT_SERIALIZER_PARITY_EN defined: data 8'b0000_0111 -> 9 bits, final bit=1. frame_done and load_ready are high in the 9th cycle only.
